sme_job_sched: RTL
==================

Name: sme_job_sched

Overview:
- Front-end scheduler for the single string-match engine (SME).
- NREQ requesters each submit a job: a string, then a pattern, as a byte stream. Requesters may insert bubbles.
- The block arbitrates round-robin, buffers one job, checks lengths and ordering, and replays the job contiguously on the SME chardata/isstring/ispattern bus.
- It waits for the SME result pulse and returns match/index to the owning requester over a valid/ready response channel.

Parameters:
- NREQ, 2, number of requesters (2..4).
- IDW, 2, requester-id width; NREQ <= 2**IDW.
- TIMEOUT, 512, max cycles in WAIT before forcing an error response.
- STR_MAX, 32, string buffer depth (SME limit).
- PAT_MAX, 8, pattern buffer depth (SME limit).

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- rq_valid  in  NREQ  per-requester beat valid
- rq_data  in  8*NREQ  per-requester char; requester i uses bits [8i+7:8i]
- rq_ispat  in  NREQ  1 = pattern char, 0 = string char
- rq_last  in  NREQ  final beat of job
- rq_ready  out  NREQ  beat accepted when valid & ready
- sme_chardata  out  8  char to SME
- sme_isstring  out  1  string strobe to SME
- sme_ispattern  out  1  pattern strobe to SME
- sme_valid  in  1  SME result pulse
- sme_match  in  1  SME match flag
- sme_match_index  in  5  SME match index
- resp_valid  out  1  response valid
- resp_ready  in  1  response accepted
- resp_id  out  IDW  owning requester
- resp_match  out  1  match result
- resp_index  out  5  match index
- resp_err  out  1  job rejected or timed out

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset values:
  - All outputs 0, except resp_index = 5'h1F.
  - State IDLE, RR pointer 0.
- Reset mid-operation: abandons the job, drops the buffer, returns to IDLE. The SME must share the same reset event.
- States:
  - IDLE: select first i with rq_valid[i] set, searching from the RR pointer upward with wrap. Latch grant g and go to LOAD the next cycle. No request: stay.
  - LOAD:
    - rq_ready[g]=1; all other ready bits 0.
    - An accepted string beat stores to sbuf[slen] and slen++. An accepted pattern beat stores to pbuf[plen] and plen++.
    - Error conditions: string beat after any pattern beat, slen at STR_MAX, or plen at PAT_MAX. The beat is dropped and the sticky err is set; LOAD continues until last.
    - On last beat: if err, slen==0 or plen==0, go to RESP (SME untouched). Else go to PLAY.
  - PLAY:
    - One char per cycle, registered: sbuf[0..slen-1] with sme_isstring=1, then pbuf[0..plen-1] with sme_ispattern=1.
    - No gaps; takes exactly slen+plen cycles.
    - Then flags drop to 0 and state goes to WAIT.
  - WAIT:
    - On sme_valid: capture match and index, go to RESP.
    - Timeout counter reaches TIMEOUT: err=1, resp_match=0, resp_index=5'h1F, go to RESP.
  - RESP:
    - resp_valid=1 with resp_id=g. All resp_* fields are stable until resp_ready.
    - On handshake: RR pointer = (g+1) mod NREQ, clear slen/plen/err, go to IDLE.
- resp_match and resp_index pass SME values unmodified. An error response has resp_match=0 and resp_index=5'h1F.
- Simultaneous events:
  - sme_valid in the same cycle as timeout expiry: the sme_valid result wins, err=0.
  - rq_valid and rq_last on a dropped beat still terminate LOAD.
- sme_valid outside WAIT is ignored.
- Back-to-back jobs: IDLE may re-grant the cycle after the RESP handshake. The SME accepts chars the cycle after its result pulse.

Optional Feature:
- SME_JOB_SCHED_PERF_EN defined:
  - Adds outputs perf_jobs[15:0], perf_matches[15:0] and perf_errs[15:0], all reset to 0.
  - Each increments on the RESP handshake per outcome, and saturates at 16'hFFFF.
- Undefined: ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Req0 sends string "abcd" with a bubble between 'b' and 'c', then pattern "cd" with last; SME model returns match=1, index=2 -> PLAY drives 6 contiguous beats, then resp_valid with id=0, match=1, index=2, err=0.
- Req0 and req1 request together in IDLE after reset -> req0 is served first, then req1. Next, both again: req0 first (pointer returns to 0 after serving req1).
- Req1 sends 33 string chars plus a 1-char pattern -> 33rd char dropped, SME flags never asserted, resp id=1, err=1, match=0, index=31.
- Pattern beat then string beat in one job -> err=1, no SME traffic. Job with zero pattern chars -> err=1.
- SME model never pulses sme_valid -> resp after TIMEOUT cycles in WAIT with err=1. resp_ready held low 5 cycles -> fields stable, no new grant.
- reset_n asserted mid-PLAY -> outputs return to reset values immediately. The next job after release completes normally.

Source files
------------

// File: rtl/sme_job_sched.sv
// Front-end job scheduler for the string-match engine: round-robin intake, one-job buffer, contiguous replay.
// Optional SME_JOB_SCHED_PERF_EN adds saturating job/match/error counters.
module sme_job_sched #(
  parameter int NREQ    = 2,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 512,
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   rq_valid,
  input  logic [8*NREQ-1:0] rq_data,
  input  logic [NREQ-1:0]   rq_ispat,
  input  logic [NREQ-1:0]   rq_last,
  output logic [NREQ-1:0]   rq_ready,
  output logic [7:0]        sme_chardata,
  output logic              sme_isstring,
  output logic              sme_ispattern,
  input  logic              sme_valid,
  input  logic              sme_match,
  input  logic [4:0]        sme_match_index,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic              resp_match,
  output logic [4:0]        resp_index,
  output logic              resp_err
`ifdef SME_JOB_SCHED_PERF_EN
  ,
  output logic [15:0]       perf_jobs,
  output logic [15:0]       perf_matches,
  output logic [15:0]       perf_errs
`endif
);

  localparam int SAW = $clog2(STR_MAX);
  localparam int SLW = $clog2(STR_MAX + 1);
  localparam int PAW = $clog2(PAT_MAX);
  localparam int PLW = $clog2(PAT_MAX + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr, g;
  logic [NREQ-1:0] gmask;
  logic [SLW-1:0]  slen, sidx;
  logic [PLW-1:0]  plen, pidx;
  logic [TW-1:0]   tcnt;
  logic            err;
  logic [7:0]      sbuf [STR_MAX];
  logic [7:0]      pbuf [PAT_MAX];

  logic            sel_found;
  logic [IDW-1:0]  sel_id;
  logic [NREQ-1:0] sel_oh;
  logic [7:0]      b_data;
  logic            b_pat, b_last, beat, drop, s_we, p_we, str_ok, pat_ok;

  // Two passes give the wrap-around search: first at/above the pointer, then from 0.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    sel_oh    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!sel_found && rq_valid[i] && i >= 32'(rr_ptr)) begin
        sel_found = 1'b1;
        sel_id    = IDW'(i);
        sel_oh[i] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!sel_found && rq_valid[i]) begin
        sel_found = 1'b1;
        sel_id    = IDW'(i);
        sel_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    b_data = '0;
    b_pat  = 1'b0;
    b_last = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gmask[i]) begin
        b_data = rq_data[8*i +: 8];
        b_pat  = rq_ispat[i];
        b_last = rq_last[i];
      end
    end
  end

  // A non-empty pattern buffer means a pattern beat has already been seen.
  assign beat   = |(rq_valid & rq_ready);
  assign drop   = b_pat ? (plen == PLW'(PAT_MAX))
                        : ((plen != '0) || (slen == SLW'(STR_MAX)));
  assign s_we   = beat && !b_pat && !drop;
  assign p_we   = beat &&  b_pat && !drop;
  assign str_ok = (slen != '0) || s_we;
  assign pat_ok = (plen != '0) || p_we;

  always_ff @(posedge clk) begin
    if (s_we) sbuf[slen[SAW-1:0]] <= b_data;
    if (p_we) pbuf[plen[PAW-1:0]] <= b_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      g             <= '0;
      gmask         <= '0;
      rq_ready      <= '0;
      slen          <= '0;
      plen          <= '0;
      sidx          <= '0;
      pidx          <= '0;
      tcnt          <= '0;
      err           <= 1'b0;
      sme_chardata  <= '0;
      sme_isstring  <= 1'b0;
      sme_ispattern <= 1'b0;
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      resp_match    <= 1'b0;
      resp_index    <= 5'h1F;
      resp_err      <= 1'b0;
`ifdef SME_JOB_SCHED_PERF_EN
      perf_jobs     <= '0;
      perf_matches  <= '0;
      perf_errs     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            g        <= sel_id;
            gmask    <= sel_oh;
            rq_ready <= sel_oh;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (beat) begin
            if (s_we) slen <= slen + 1'b1;
            if (p_we) plen <= plen + 1'b1;
            if (drop) err  <= 1'b1;
            if (b_last) begin
              rq_ready <= '0;
              sidx     <= '0;
              pidx     <= '0;
              if (err || drop || !str_ok || !pat_ok) begin
                resp_valid <= 1'b1;
                resp_id    <= g;
                resp_match <= 1'b0;
                resp_index <= 5'h1F;
                resp_err   <= 1'b1;
                state      <= S_RESP;
              end else begin
                state <= S_PLAY;
              end
            end
          end
        end
        S_PLAY: begin
          if (sidx != slen) begin
            sme_chardata <= sbuf[sidx[SAW-1:0]];
            sme_isstring <= 1'b1;
            sidx         <= sidx + 1'b1;
          end else if (pidx != plen) begin
            sme_chardata  <= pbuf[pidx[PAW-1:0]];
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b1;
            pidx          <= pidx + 1'b1;
          end else begin
            sme_chardata  <= '0;
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
            tcnt          <= '0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A result arriving on the expiry cycle takes priority over the timeout.
          if (sme_valid) begin
            resp_valid <= 1'b1;
            resp_id    <= g;
            resp_match <= sme_match;
            resp_index <= sme_match_index;
            resp_err   <= 1'b0;
            state      <= S_RESP;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            resp_valid <= 1'b1;
            resp_id    <= g;
            resp_match <= 1'b0;
            resp_index <= 5'h1F;
            resp_err   <= 1'b1;
            state      <= S_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
            slen       <= '0;
            plen       <= '0;
            err        <= 1'b0;
            state      <= S_IDLE;
`ifdef SME_JOB_SCHED_PERF_EN
            if (perf_jobs != '1) perf_jobs <= perf_jobs + 1'b1;
            if (resp_err && perf_errs != '1) perf_errs <= perf_errs + 1'b1;
            if (!resp_err && resp_match && perf_matches != '1)
              perf_matches <= perf_matches + 1'b1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
